fixed_p_std_div_pipe: RTL
=========================

// Module: fixed_p_std_div_pipe
// PURPOSE
//  Synthesizable multi-cycle unsigned fixed-point divider; successor to the combinational fixed_p_std_div.
//  Computes (left / right) in Q(INT_WIDTH.FRACT_WIDTH) with a restoring shift-subtract datapath,
//  one quotient bit per cycle. Also reports remainder, divide-by-zero and quotient overflow.
//  Calyx go/done handshake; drop-in for compiled designs needing real fixed-point division.
// PARAMETERS
//  WIDTH        32  total operand/result width; must equal INT_WIDTH+FRACT_WIDTH
//  INT_WIDTH    8   integer bits
//  FRACT_WIDTH  24  fraction bits; dividend is left*2^FRACT_WIDTH (N = WIDTH+FRACT_WIDTH bits)
// PORTS
//  clk            in   1      clock, rising edge
//  reset_n        in   1      asynchronous reset, active-low
//  go             in   1      start request; sampled only in IDLE
//  left           in   WIDTH  dividend, unsigned fixed-point; captured when go is accepted
//  right          in   WIDTH  divisor, unsigned fixed-point; captured when go is accepted
//  out_quotient   out  WIDTH  quotient, low WIDTH bits of floor(left*2^F / right)
//  out_remainder  out  WIDTH  remainder of that integer division (< right)
//  div_by_zero    out  1      last op had right==0
//  overflow       out  1      last op's full quotient needed more than WIDTH bits
//  done           out  1      one-cycle pulse; results valid while high and held until next accept
// BEHAVIOUR
//  - Elaboration $error if INT_WIDTH+FRACT_WIDTH != WIDTH.
//  - Reset (reset_n=0, async): state=IDLE; out_quotient, out_remainder, div_by_zero, overflow, done = 0;
//    iteration counter and internal regs cleared. Release is synchronous to clk.
//  - States IDLE, BUSY, DONE. done = (state==DONE), registered, no comb path from go.
//  - IDLE & go & right!=0: capture dividend D={left,F'b0} (N bits), divisor, rem=0, count=0 -> BUSY.
//  - IDLE & go & right==0: -> DONE; out_quotient=all ones, out_remainder=0, div_by_zero=1, overflow=0.
//  - BUSY, per edge: rem={rem,D[msb]}; D<<=1; if rem>=divisor {rem-=divisor; qbit=1} else qbit=0;
//    quotient shifts in qbit; count++. rem datapath is WIDTH+1 bits wide (no truncation on the shift).
//    After N iterations (count==N-1 on that edge) -> DONE, loading outputs:
//    out_quotient=q[WIDTH-1:0], out_remainder=rem[WIDTH-1:0], overflow=|q[N-1:WIDTH], div_by_zero=0.
//  - Latency: done is high in the cycle after edge N+1 counted from (and including) the accepting edge;
//    div-by-zero: after edge 1. Exactly one cycle high.
//  - DONE -> IDLE unconditionally on the next edge; go during DONE is ignored (not queued).
//    go high in the first IDLE cycle after DONE starts a new op (min issue interval N+2 cycles).
//  - go, left, right changes while BUSY/DONE are ignored; operands are used from capture only.
//  - Result outputs hold their value from DONE until the next DONE or reset; they never change
//    while BUSY.
//  - Rounding: truncation toward zero. Overflow: quotient wraps to low WIDTH bits, flag set.
//  - reset_n asserted mid-BUSY aborts the op; no done pulse; outputs cleared.
// TESTING (WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4, N=12)
//  1. left=0x30 (3.0), right=0x20 (2.0), go 1 cycle -> done after 13 edges; quotient=0x18 (1.5),
//     remainder=0x00, flags 0.
//  2. left=0x10 (1.0), right=0x30 (3.0) -> quotient=0x05, remainder=0x10, flags 0.
//  3. left=0xF0 (15.0), right=0x01 (0.0625) -> full quotient 3840; out_quotient=0x00, overflow=1.
//  4. right=0x00, left=0x55 -> done after 1 edge; quotient=0xFF, remainder=0, div_by_zero=1.
//  5. go held high continuously with case 1 operands -> done pulses every 14 cycles, each result
//     0x18; operand changes while BUSY have no effect.
//  6. reset_n low at iteration 5 of case 2 -> all outputs 0, IDLE; a fresh go then yields case 2
//     results with normal latency.

Source files
------------

// File: rtl/fixed_p_std_div_pipe.sv
// Multi-cycle unsigned fixed-point divider (restoring shift-subtract, one quotient bit per cycle).
// The dividend is left*2^FRACT_WIDTH and the handshake is Calyx-style go/done.
module fixed_p_std_div_pipe #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             done
);

  localparam int N  = WIDTH + FRACT_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_width_check
    $error("fixed_p_std_div_pipe: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [N-1:0]     quot_q, quot_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // The partial remainder is always < divisor, so the shifted value needs exactly one extra bit.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next;
  logic [N-1:0]     quot_shift;

  assign rem_shift  = {rem_q, dividend_q[N-1]};
  assign rem_ge     = (rem_shift >= {1'b0, divisor_q});
  assign rem_sub    = rem_shift - {1'b0, divisor_q};
  assign rem_next   = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_shift = {quot_q[N-2:0], rem_ge};

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    count_d    = count_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (right == '0) begin
            state_d    = ST_DONE;
            out_quot_d = '1;
            out_rem_d  = '0;
            dbz_d      = 1'b1;
            ovf_d      = 1'b0;
          end else begin
            state_d    = ST_BUSY;
            dividend_d = {left, {FRACT_WIDTH{1'b0}}};
            divisor_d  = right;
            rem_d      = '0;
            quot_d     = '0;
            count_d    = '0;
          end
        end
      end
      ST_BUSY: begin
        dividend_d = dividend_q << 1;
        rem_d      = rem_next;
        quot_d     = quot_shift;
        count_d    = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d    = ST_DONE;
          out_quot_d = quot_shift[WIDTH-1:0];
          out_rem_d  = rem_next;
          dbz_d      = 1'b0;
          ovf_d      = |quot_shift[N-1:WIDTH];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      count_q    <= '0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      count_q    <= count_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_quotient  = out_quot_q;
  assign out_remainder = out_rem_q;
  assign div_by_zero   = dbz_q;
  assign overflow      = ovf_q;
  assign done          = (state_q == ST_DONE);

endmodule
